// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_bin_seq
//  Purpose  : Sequential packed-BCD to binary decoder. An operand is accepted
//             over a valid/ready handshake and converted by reverse
//             double-dabble, one bit per clock (W = 4*DIGITS clocks). The
//             result is returned over a second valid/ready handshake.
//  Options  : `define BCDCONV_INVALID_DIGIT_EN to flag operands that contain
//             a digit above 9 (err=1, bin_out forced to 0 in DONE).
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bin_out,
    output logic                  err,
    output logic                  busy
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [W-1:0]      bcd_q,   bcd_d;
    logic [W-1:0]      bin_q,   bin_d;

    logic [2*W-1:0]    pair_shift;
    logic [W-1:0]      bcd_shift;
    logic [W-1:0]      bin_shift;
    logic [W-1:0]      bcd_adj;

    // One reverse double-dabble step: shift the BCD/binary pair right by one
    assign pair_shift = {bcd_q, bin_q} >> 1;
    assign bcd_shift  = pair_shift[2*W-1:W];
    assign bin_shift  = pair_shift[W-1:0];

    // After the shift, any nibble >= 8 had a "ten" pass through it; remove 3
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
        assign bcd_adj[4*gi +: 4] = bcd_shift[4*gi + 3] ? (bcd_shift[4*gi +: 4] - 4'd3)
                                                       : bcd_shift[4*gi +: 4];
    end

`ifdef BCDCONV_INVALID_DIGIT_EN
    logic              err_q, err_d;
    logic [DIGITS-1:0] digit_bad;

    // Flag every incoming nibble that is not a decimal digit
    for (genvar gd = 0; gd < DIGITS; gd++) begin : g_digit_chk
        assign digit_bad[gd] = (bcd_in[4*gd +: 4] > 4'd9);
    end
`endif

    // Next-state, datapath and handshake control
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
`ifdef BCDCONV_INVALID_DIGIT_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    bcd_d   = bcd_in;
                    bin_d   = '0;
                    count_d = '0;
                    state_d = ST_BUSY;
`ifdef BCDCONV_INVALID_DIGIT_EN
                    err_d   = |digit_bad;
`endif
                end
            end
            ST_BUSY: begin
                bcd_d   = bcd_adj;
                bin_d   = bin_shift;
                count_d = count_q + CW'(1);
                if (count_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
`ifdef BCDCONV_INVALID_DIGIT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Cancel wins over both handshakes in the same cycle
        if (abort) begin
            state_d = ST_IDLE;
            count_d = '0;
`ifdef BCDCONV_INVALID_DIGIT_EN
            err_d   = 1'b0;
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
        end
    end

`ifdef BCDCONV_INVALID_DIGIT_EN
    // Invalid-digit flag, held from accept until the result leaves
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err     = (state_q == ST_DONE) && err_q;
    assign bin_out = ((state_q == ST_DONE) && !err_q) ? bin_q : '0;
`else
    assign err     = 1'b0;
    assign bin_out = (state_q == ST_DONE) ? bin_q : '0;
`endif

    assign in_ready  = (state_q == ST_IDLE) && !abort;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
